// File: rtl/rv32_branch_ctrl_if.sv
// Decode/fetch-facing bus of the branch controller.
// slave  : the controller side (takes the decoded branch, drives redirect/stall).
// master : the core/testbench side.
// Signals: id_valid, id_pc, id_imm, id_rs1, is_cond, is_jmp, is_jalr,
//          branch_taken, fetch_ready (to controller); id_accept, stall, flush,
//          redirect_valid, redirect_pc, misalign_exc (from controller).
// When BRANCH_PERF_EN is defined the bus also carries perf_branches/perf_taken.
interface rv32_branch_ctrl_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [31:0] id_rs1;
  logic        is_cond;
  logic        is_jmp;
  logic        is_jalr;
  logic        branch_taken;
  logic        fetch_ready;
  logic        id_accept;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_exc;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_taken;
`endif

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1, is_cond, is_jmp, is_jalr,
           branch_taken, fetch_ready,
    output id_accept, stall, flush, redirect_valid, redirect_pc, misalign_exc
`ifdef BRANCH_PERF_EN
    , output perf_branches, perf_taken
`endif
  );

  modport master (
    output id_valid, id_pc, id_imm, id_rs1, is_cond, is_jmp, is_jalr,
           branch_taken, fetch_ready,
    input  id_accept, stall, flush, redirect_valid, redirect_pc, misalign_exc
`ifdef BRANCH_PERF_EN
    , input perf_branches, perf_taken
`endif
  );
endinterface

// File: rtl/rv32_branch_ctrl.sv
// rv32_branch_ctrl: control-flow resolution for the single-stage rv32imc core.
// Takes a resolved branch/jump from decode, computes its target, issues a
// valid/ready redirect to fetch and holds decode (stall) / kills wrong-path
// slots (flush) until the redirect is consumed and FLUSH_CYCLES have elapsed.
// Ports: clk, rst (async, active high), bus (rv32_branch_ctrl_if.slave).
// Parameters: FLUSH_CYCLES (>=1) cycles in FLUSH after the redirect handshake;
//             IALIGN 16 (C extension) or 32 target alignment.
// Optional: define BRANCH_PERF_EN to add the perf_branches / perf_taken
//           counters on the bus.
module rv32_branch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int IALIGN       = 16
) (
  input  logic               clk,
  input  logic               rst,
  rv32_branch_ctrl_if.slave  bus
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [31:0] pc_sum, jalr_sum, target;
  logic        use_jalr, taken, misalign, accept, take_ok;

  // Target calculation; JALR only counts when is_jmp is also set.
  assign use_jalr = bus.is_jmp & bus.is_jalr;
  assign pc_sum   = bus.id_pc + bus.id_imm;
  assign jalr_sum = bus.id_rs1 + bus.id_imm;
  assign target   = use_jalr ? (jalr_sum & ~32'h1) : pc_sum;

  generate
    if (IALIGN == 32) begin : g_al32
      assign misalign = |target[1:0];
    end else begin : g_al16
      assign misalign = target[0];
    end
  endgenerate

  // A jump wins when both is_cond and is_jmp are set.
  assign taken   = bus.is_jmp | (bus.is_cond & bus.branch_taken);
  assign accept  = bus.id_valid & (state == IDLE);
  assign take_ok = accept & taken & ~misalign;

  assign bus.id_accept      = accept;
  assign bus.stall          = (state != IDLE);
  assign bus.flush          = (state != IDLE);
  assign bus.redirect_valid = (state == REDIRECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (take_ok) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (bus.fetch_ready) begin
          state_nxt = FLUSH;
          cnt_nxt   = CW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // redirect_pc only loads on a new accepted redirect, so it stays stable
  // through any fetch backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.redirect_pc  <= '0;
      bus.misalign_exc <= 1'b0;
    end else begin
      bus.misalign_exc <= accept & taken & misalign;
      if (take_ok) bus.redirect_pc <= target;
    end
  end

`ifdef BRANCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.perf_branches <= '0;
      bus.perf_taken    <= '0;
    end else begin
      if (accept)  bus.perf_branches <= bus.perf_branches + 32'd1;
      if (take_ok) bus.perf_taken    <= bus.perf_taken + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rv32_branch_ctrl.sv
// Bench for rv32_branch_ctrl: two instances (IALIGN=16 and IALIGN=32) share
// one stimulus stream and are checked every cycle against a cycle-level
// reference model, plus hand-computed literal expectations.
module tb_rv32_branch_ctrl;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_branch_ctrl_if b16 ();
  rv32_branch_ctrl_if b32 ();

  rv32_branch_ctrl #(.FLUSH_CYCLES(FC), .IALIGN(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  rv32_branch_ctrl #(.FLUSH_CYCLES(FC), .IALIGN(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

  assign b32.id_valid     = b16.id_valid;
  assign b32.id_pc        = b16.id_pc;
  assign b32.id_imm       = b16.id_imm;
  assign b32.id_rs1       = b16.id_rs1;
  assign b32.is_cond      = b16.is_cond;
  assign b32.is_jmp       = b16.is_jmp;
  assign b32.is_jalr      = b16.is_jalr;
  assign b32.branch_taken = b16.branch_taken;
  assign b32.fetch_ready  = b16.fetch_ready;

  logic        o_acc [2], o_stall [2], o_flush [2], o_rv [2], o_mis [2];
  logic [31:0] o_rpc [2];
  assign o_acc[0] = b16.id_accept;   assign o_acc[1] = b32.id_accept;
  assign o_stall[0] = b16.stall;     assign o_stall[1] = b32.stall;
  assign o_flush[0] = b16.flush;     assign o_flush[1] = b32.flush;
  assign o_rv[0] = b16.redirect_valid; assign o_rv[1] = b32.redirect_valid;
  assign o_mis[0] = b16.misalign_exc;  assign o_mis[1] = b32.misalign_exc;
  assign o_rpc[0] = b16.redirect_pc;   assign o_rpc[1] = b32.redirect_pc;
`ifdef BRANCH_PERF_EN
  logic [31:0] o_pb [2], o_pt [2];
  assign o_pb[0] = b16.perf_branches; assign o_pb[1] = b32.perf_branches;
  assign o_pt[0] = b16.perf_taken;    assign o_pt[1] = b32.perf_taken;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: a pending redirect flag plus a count of flush cycles
  // still owed; decode is blocked whenever either is outstanding.
  bit          m_redir [2];
  int          m_flush [2];
  logic [31:0] m_rpc [2];
  bit          m_mis [2];
  logic [31:0] m_br [2], m_tk [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int k);
    return m_redir[k] || (m_flush[k] > 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_redir[k] = 0; m_flush[k] = 0; m_rpc[k] = '0; m_mis[k] = 0;
      m_br[k] = '0; m_tk[k] = '0;
    end
  endtask

  task automatic compare_regs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall[%0d]", k), {31'd0, o_stall[k]}, {31'd0, m_busy(k)});
      chk($sformatf("flush[%0d]", k), {31'd0, o_flush[k]}, {31'd0, m_busy(k)});
      chk($sformatf("redirect_valid[%0d]", k), {31'd0, o_rv[k]}, {31'd0, m_redir[k]});
      chk($sformatf("redirect_pc[%0d]", k), o_rpc[k], m_rpc[k]);
      chk($sformatf("misalign_exc[%0d]", k), {31'd0, o_mis[k]}, {31'd0, m_mis[k]});
`ifdef BRANCH_PERF_EN
      chk($sformatf("perf_branches[%0d]", k), o_pb[k], m_br[k]);
      chk($sformatf("perf_taken[%0d]", k), o_pt[k], m_tk[k]);
`endif
    end
  endtask

  // One clock: inputs must already be set (low phase). Checks the
  // combinational accept, advances the model at the edge, checks registers.
  task automatic step();
    bit acc [2];
    bit tk, mis;
    logic [31:0] t;
    #1;
    for (int k = 0; k < 2; k++) begin
      acc[k] = b16.id_valid && !m_busy(k);
      chk($sformatf("id_accept[%0d]", k), {31'd0, o_acc[k]}, {31'd0, acc[k]});
    end
    @(posedge clk);
    tk = b16.is_jmp || (b16.is_cond && b16.branch_taken);
    t  = (b16.is_jmp && b16.is_jalr) ? ((b16.id_rs1 + b16.id_imm) & 32'hFFFF_FFFE)
                                     : (b16.id_pc + b16.id_imm);
    for (int k = 0; k < 2; k++) begin
      mis = (k == 1) ? (t[1:0] != 2'b00) : t[0];
      m_mis[k] = acc[k] && tk && mis;
      if (acc[k]) m_br[k]++;
      if (m_redir[k]) begin
        if (b16.fetch_ready) begin m_redir[k] = 0; m_flush[k] = FC; end
      end else if (m_flush[k] > 0) begin
        m_flush[k]--;
      end else if (acc[k] && tk && !mis) begin
        m_redir[k] = 1; m_rpc[k] = t; m_tk[k]++;
      end
    end
    #1;
    compare_regs();
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input bit c, input bit j, input bit jr,
                        input bit bt, input bit fr);
    b16.id_valid = v; b16.id_pc = pc; b16.id_imm = imm; b16.id_rs1 = rs1;
    b16.is_cond = c; b16.is_jmp = j; b16.is_jalr = jr; b16.branch_taken = bt;
    b16.fetch_ready = fr;
  endtask

  task automatic drain();
    int n = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    while ((o_stall[0] || o_stall[1]) && n < 20) begin n++; step(); end
    chk("drain_bound", {31'd0, (o_stall[0] || o_stall[1])}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_regs();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    @(negedge clk);
    do_reset();

    // BEQ not taken
    set_in(1, 32'h100, 32'h20, 0, 1, 0, 0, 0, 1);
    step();
    chk("beq_nt_stall", {31'd0, o_stall[0]}, 32'd0);
    chk("beq_nt_rv", {31'd0, o_rv[0]}, 32'd0);

    // JAL, fetch ready: redirect next cycle, stall for 1+FC cycles
    set_in(1, 32'h100, 32'h20, 0, 0, 1, 0, 0, 1);
    step();
    chk("jal_rpc", o_rpc[0], 32'h120);
    chk("jal_rv", {31'd0, o_rv[0]}, 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    n = 0;
    while (o_stall[0] && n < 20) begin n++; step(); end
    chk("jal_stall_cycles", n, 1 + FC);

    // JALR with 3 cycles of backpressure
    set_in(1, 32'h0, 32'h10, 32'h2001, 0, 1, 1, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("jalr_rpc_hold", o_rpc[0], 32'h2010);
      chk("jalr_rv_hold", {31'd0, o_rv[0]}, 32'd1);
      step();
    end
    b16.fetch_ready = 1'b1;
    step();
    chk("jalr_flush_rv", {31'd0, o_rv[0]}, 32'd0);
    chk("jalr_flush_stall", {31'd0, o_stall[0]}, 32'd1);
    drain();

    // JAL to 0x2: misaligned only under IALIGN=32
    set_in(1, 32'h0, 32'h2, 0, 0, 1, 0, 0, 1);
    step();
    chk("al32_mis", {31'd0, o_mis[1]}, 32'd1);
    chk("al32_rv", {31'd0, o_rv[1]}, 32'd0);
    chk("al16_rpc", o_rpc[0], 32'h2);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("al32_mis_pulse", {31'd0, o_mis[1]}, 32'd0);
    drain();

    // Wrap, then async reset in FLUSH
    set_in(1, 32'hFFFF_FFF0, 32'h20, 0, 0, 1, 0, 0, 1);
    step();
    chk("wrap_rpc", o_rpc[0], 32'h10);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("in_flush", {31'd0, o_stall[0]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_stall", {31'd0, o_stall[0]}, 32'd0);
    chk("rst_flush", {31'd0, o_flush[0]}, 32'd0);
    chk("rst_rpc", o_rpc[0], 32'd0);
    @(negedge clk);
    do_reset();

`ifdef BRANCH_PERF_EN
    set_in(1, 32'h100, 32'h20, 0, 1, 0, 0, 0, 1);
    step();
    set_in(1, 32'h100, 32'h20, 0, 0, 1, 0, 0, 1);
    step();
    drain();
    set_in(1, 32'h200, 32'h40, 0, 1, 0, 0, 1, 1);
    step();
    drain();
    chk("perf_branches", o_pb[0], 32'd3);
    chk("perf_taken", o_pt[0], 32'd2);
`endif

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm;
      imm = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 255));
      set_in($urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFE, imm, $urandom,
             $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3) != 0);
      step();
      if (i == 400) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_regs();
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
